iserdes_prbs_checker: RTL and testbench



---
 rtl/iserdes_chk_pkg.sv | 20 ++
 rtl/iserdes_prbs_checker_word_step.sv | 28 ++
 rtl/iserdes_prbs_checker.sv | 136 +++++++++++++
 tb/tb_iserdes_prbs_checker.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iserdes_chk_pkg.sv
// Shared types and constants for the ISERDES PRBS-7 receive checker.
// PRBS-7 uses the polynomial x^7+x^6+1, which taps history bits 6 and 5.
package iserdes_chk_pkg;

    typedef enum logic [1:0] {
        ACQUIRE,
        LOCKING,
        LOCKED
    } chk_state_t;

    localparam int PRBS_LEN   = 7;
    localparam int PRBS_TAP_A = 6;
    localparam int PRBS_TAP_B = 5;

    // Number of words needed to refill the whole history register.
    function automatic int acq_words(input int data_width);
        return (PRBS_LEN + data_width - 1) / data_width;
    endfunction

endpackage

// File: rtl/iserdes_prbs_checker_word_step.sv
// Combinational PRBS-7 step across one received word, LSB (earliest bit) first.
// History is always fed from received bits, so the checker re-synchronizes by itself.
module prbs_word_step
    import iserdes_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [PRBS_LEN-1:0]   hist,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [PRBS_LEN-1:0]   next_hist,
    output logic                  bad
);

    logic [PRBS_LEN-1:0] walk;

    always_comb begin
        walk = hist;
        bad  = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if ((walk[PRBS_TAP_A] ^ walk[PRBS_TAP_B]) != word[i]) begin
                bad = 1'b1;
            end
            walk = {walk[PRBS_LEN-2:0], word[i]};
        end
        next_hist = walk;
    end

endmodule

// File: rtl/iserdes_prbs_checker.sv
// Per-lane PRBS-7 checker for ISERDES words: acquires lock, detects lock loss,
// and keeps a sticky error flag plus a saturating bad-word counter.
module iserdes_prbs_checker
    import iserdes_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LOCK_WORDS = 16,
    parameter int LOSS_WORDS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  I_VLD,
    input  logic [DATA_WIDTH-1:0] I_DAT,
    output logic                  O_LOCKED,
    output logic                  O_ERROR,
    output logic [CNT_WIDTH-1:0]  O_ERR_CNT,
    output logic                  O_LOSS
);

    localparam logic [3:0] ACQ_TARGET  = 4'(acq_words(DATA_WIDTH));
    localparam logic [7:0] LOCK_TARGET = 8'(LOCK_WORDS);
    localparam logic [7:0] LOSS_TARGET = 8'(LOSS_WORDS);

    chk_state_t          state, state_next;
    logic [PRBS_LEN-1:0] hist, hist_next, step_hist;
    logic                step_bad, hist_zero, locked_bad, lock_lost;
    logic [3:0]          acq_cnt, acq_cnt_next;
    logic [7:0]          good_run, good_run_next, bad_run, bad_run_next;
    logic                locked_next, error_next, loss_next;
    logic [CNT_WIDTH-1:0] err_cnt_next;

    prbs_word_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .hist      (hist),
        .word      (I_DAT),
        .next_hist (step_hist),
        .bad       (step_bad)
    );

    assign hist_zero  = (step_hist == '0);
    assign locked_bad = I_VLD && (state == LOCKED) && step_bad;
    assign lock_lost  = locked_bad && ((bad_run + 8'd1) == LOSS_TARGET);

    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= ACQUIRE;
            hist      <= '0;
            acq_cnt   <= '0;
            good_run  <= '0;
            bad_run   <= '0;
            O_LOCKED  <= 1'b0;
            O_ERROR   <= 1'b0;
            O_ERR_CNT <= '0;
            O_LOSS    <= 1'b0;
        end else begin
            state     <= state_next;
            hist      <= hist_next;
            acq_cnt   <= acq_cnt_next;
            good_run  <= good_run_next;
            bad_run   <= bad_run_next;
            O_LOCKED  <= locked_next;
            O_ERROR   <= error_next;
            O_ERR_CNT <= err_cnt_next;
            O_LOSS    <= loss_next;
        end
    end

    // The acquire count restarts whenever history collapses to all zeros, so lock
    // is only attempted once a full window of non-trivial bits has been loaded.
    always_comb begin
        state_next    = state;
        hist_next     = hist;
        acq_cnt_next  = acq_cnt;
        good_run_next = good_run;
        bad_run_next  = bad_run;
        if (I_VLD) begin
            hist_next = step_hist;
            unique case (state)
                ACQUIRE: begin
                    good_run_next = '0;
                    bad_run_next  = '0;
                    if (hist_zero) begin
                        acq_cnt_next = '0;
                    end else if ((acq_cnt + 4'd1) >= ACQ_TARGET) begin
                        acq_cnt_next = '0;
                        state_next   = LOCKING;
                    end else begin
                        acq_cnt_next = acq_cnt + 4'd1;
                    end
                end
                LOCKING: begin
                    acq_cnt_next = '0;
                    bad_run_next = '0;
                    if (hist_zero) begin
                        good_run_next = '0;
                        state_next    = ACQUIRE;
                    end else if (step_bad) begin
                        good_run_next = '0;
                    end else if ((good_run + 8'd1) == LOCK_TARGET) begin
                        good_run_next = '0;
                        state_next    = LOCKED;
                    end else begin
                        good_run_next = good_run + 8'd1;
                    end
                end
                LOCKED: begin
                    acq_cnt_next = '0;
                    if (lock_lost) begin
                        good_run_next = '0;
                        bad_run_next  = '0;
                        state_next    = ACQUIRE;
                    end else if (step_bad) begin
                        bad_run_next = bad_run + 8'd1;
                    end else begin
                        bad_run_next = '0;
                    end
                end
                default: state_next = ACQUIRE;
            endcase
        end
    end

    always_comb begin
        locked_next  = (state_next == LOCKED);
        loss_next    = lock_lost;
        error_next   = O_ERROR;
        err_cnt_next = O_ERR_CNT;
        if (locked_bad) begin
            error_next = 1'b1;
            if (O_ERR_CNT != '1) begin
                err_cnt_next = O_ERR_CNT + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iserdes_prbs_checker.sv
// Self-checking bench for iserdes_prbs_checker: two instances (8-bit and 3-bit/4-bit counter)
// driven in turn and compared every cycle against a bit-stream reference model.
module tb_iserdes_prbs_checker;

    localparam int M_ACQ     = 0;
    localparam int M_LOCKING = 1;
    localparam int M_LOCKED  = 2;

    logic        clk = 1'b0;
    logic        RST;
    logic        a_vld, a_locked, a_error, a_loss;
    logic [7:0]  a_dat;
    logic [15:0] a_cnt;
    logic        b_vld, b_locked, b_error, b_loss;
    logic [2:0]  b_dat;
    logic [3:0]  b_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int active = 0;
    int a_loss_cycles = 0;

    bit prbs_seq[127];
    int gen_ptr;

    bit rx_q[$];
    int m_dw, m_lock, m_loss, m_cnt_max;
    int m_mode, since_load, good_run, bad_run, exp_cnt;
    bit exp_lock, exp_err, exp_loss;

    iserdes_prbs_checker #(.DATA_WIDTH(8), .LOCK_WORDS(16), .LOSS_WORDS(4), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .RST(RST), .I_VLD(a_vld), .I_DAT(a_dat),
        .O_LOCKED(a_locked), .O_ERROR(a_error), .O_ERR_CNT(a_cnt), .O_LOSS(a_loss)
    );

    iserdes_prbs_checker #(.DATA_WIDTH(3), .LOCK_WORDS(16), .LOSS_WORDS(255), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .RST(RST), .I_VLD(b_vld), .I_DAT(b_dat),
        .O_LOCKED(b_locked), .O_ERROR(b_error), .O_ERR_CNT(b_cnt), .O_LOSS(b_loss)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_loss) a_loss_cycles++;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        if (active == 0) begin
            checkOutput({tag, "_locked"}, int'(a_locked), int'(exp_lock));
            checkOutput({tag, "_error"},  int'(a_error),  int'(exp_err));
            checkOutput({tag, "_cnt"},    int'(a_cnt),    exp_cnt);
            checkOutput({tag, "_loss"},   int'(a_loss),   int'(exp_loss));
        end else begin
            checkOutput({tag, "_locked"}, int'(b_locked), int'(exp_lock));
            checkOutput({tag, "_error"},  int'(b_error),  int'(exp_err));
            checkOutput({tag, "_cnt"},    int'(b_cnt),    exp_cnt);
            checkOutput({tag, "_loss"},   int'(b_loss),   int'(exp_loss));
        end
    endtask

    task automatic setModel(input int dw, input int lock_words, input int loss_words, input int cnt_max);
        m_dw = dw;
        m_lock = lock_words;
        m_loss = loss_words;
        m_cnt_max = cnt_max;
    endtask

    task automatic modelReset();
        rx_q.delete();
        repeat (7) rx_q.push_back(1'b0);
        m_mode = M_ACQ;
        since_load = 0;
        good_run = 0;
        bad_run = 0;
        exp_cnt = 0;
        exp_lock = 0;
        exp_err = 0;
        exp_loss = 0;
    endtask

    // rx_q holds the last seven received bits, oldest first: a PRBS-7 bit
    // must equal the XOR of the bits received seven and six positions earlier.
    task automatic modelWord(input logic [7:0] word);
        bit bad;
        bit pred;
        int ones;
        bad = 0;
        for (int i = 0; i < m_dw; i++) begin
            pred = rx_q[0] ^ rx_q[1];
            if (pred != word[i]) bad = 1;
            rx_q.push_back(word[i]);
            void'(rx_q.pop_front());
        end
        ones = 0;
        foreach (rx_q[j]) ones += int'(rx_q[j]);
        exp_loss = 0;
        case (m_mode)
            M_ACQ: begin
                since_load = (ones == 0) ? 0 : since_load + 1;
                if (since_load >= (7 + m_dw - 1) / m_dw) begin
                    m_mode = M_LOCKING;
                    since_load = 0;
                    good_run = 0;
                end
            end
            M_LOCKING: begin
                if (ones == 0) begin
                    m_mode = M_ACQ;
                    since_load = 0;
                    good_run = 0;
                end else if (bad) begin
                    good_run = 0;
                end else begin
                    good_run++;
                    if (good_run == m_lock) begin
                        m_mode = M_LOCKED;
                        good_run = 0;
                        bad_run = 0;
                    end
                end
            end
            default: begin
                if (bad) begin
                    exp_err = 1;
                    if (exp_cnt < m_cnt_max) exp_cnt++;
                    bad_run++;
                    if (bad_run == m_loss) begin
                        exp_loss = 1;
                        m_mode = M_ACQ;
                        since_load = 0;
                        bad_run = 0;
                        good_run = 0;
                    end
                end else begin
                    bad_run = 0;
                end
            end
        endcase
        exp_lock = (m_mode == M_LOCKED);
    endtask

    task automatic getWord(output logic [7:0] w);
        w = '0;
        for (int i = 0; i < m_dw; i++) begin
            w[i] = prbs_seq[gen_ptr % 127];
            gen_ptr++;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] word, input int gap);
        if (active == 0) begin
            a_vld = 1'b1;
            a_dat = word;
        end else begin
            b_vld = 1'b1;
            b_dat = word[2:0];
        end
        @(posedge clk);
        #1;
        a_vld = 1'b0;
        b_vld = 1'b0;
        modelWord(word);
        checkAll("word");
        repeat (gap) begin
            @(posedge clk);
            #1;
            exp_loss = 0;
            checkAll("idle");
        end
    endtask

    task automatic doReset();
        RST = 1'b1;
        a_vld = 1'b0;
        b_vld = 1'b0;
        @(posedge clk);
        #1;
        RST = 1'b0;
        modelReset();
        checkAll("reset");
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] w;
        RST = 1'b1;
        a_vld = 1'b0;
        a_dat = '0;
        b_vld = 1'b0;
        b_dat = '0;
        for (int n = 0; n < 7; n++) prbs_seq[n] = 1'b1;
        for (int n = 7; n < 127; n++) prbs_seq[n] = prbs_seq[n-7] ^ prbs_seq[n-6];

        active = 0;
        setModel(8, 16, 4, 65535);
        doReset();
        gen_ptr = 0;

        for (int i = 1; i <= 100; i++) begin
            getWord(w);
            applyStimulus(w, 3);
            checkOutput("lock_edge", int'(a_locked), int'(i >= 17));
        end
        checkOutput("clean_error", int'(a_error), 0);
        checkOutput("clean_cnt", int'(a_cnt), 0);

        // A flipped bit is seen three times: at itself and again six and seven bits
        // later, so flips in words 30, 31, 50 also spoil words 32 and 51.
        a_loss_cycles = 0;
        for (int i = 1; i <= 60; i++) begin
            getWord(w);
            if (i == 30 || i == 31 || i == 50) w[3] = ~w[3];
            applyStimulus(w, $urandom_range(0, 3));
        end
        checkOutput("flip_cnt", int'(a_cnt), 5);
        checkOutput("flip_error", int'(a_error), 1);
        checkOutput("flip_locked", int'(a_locked), 1);
        checkOutput("flip_no_loss", a_loss_cycles, 0);

        for (int i = 1; i <= 4; i++) begin
            getWord(w);
            applyStimulus(w ^ 8'h01, 0);
        end
        checkOutput("loss_pulse", int'(a_loss), 1);
        checkOutput("loss_locked", int'(a_locked), 0);
        checkOutput("loss_cnt", int'(a_cnt), 9);
        @(posedge clk);
        #1;
        exp_loss = 0;
        checkOutput("loss_width", int'(a_loss), 0);
        checkOutput("loss_cycles", a_loss_cycles, 1);

        for (int i = 1; i <= 17; i++) begin
            getWord(w);
            applyStimulus(w, 1);
            checkOutput("relock_edge", int'(a_locked), int'(i >= 17));
        end
        checkOutput("relock_error", int'(a_error), 1);
        checkOutput("relock_cnt", int'(a_cnt), 9);

        for (int i = 0; i < 200; i++) begin
            getWord(w);
            if ($urandom_range(0, 99) < 20) w = w ^ 8'($urandom_range(1, 255));
            applyStimulus(w, $urandom_range(0, 2));
        end
        for (int i = 0; i < 40; i++) begin
            getWord(w);
            applyStimulus(w, $urandom_range(0, 1));
        end
        checkOutput("settle_locked", int'(a_locked), 1);

        getWord(w);
        a_vld = 1'b1;
        a_dat = w ^ 8'hFF;
        RST = 1'b1;
        @(posedge clk);
        #1;
        RST = 1'b0;
        a_vld = 1'b0;
        modelReset();
        checkAll("rst_vld");
        checkOutput("rst_vld_cnt", int'(a_cnt), 0);

        active = 1;
        setModel(3, 16, 255, 15);
        doReset();
        for (int i = 0; i < 50; i++) begin
            applyStimulus(8'h00, $urandom_range(0, 2));
            checkOutput("zero_locked", int'(b_locked), 0);
        end
        gen_ptr = 0;
        for (int i = 1; i <= 19; i++) begin
            getWord(w);
            applyStimulus(w, 1);
            checkOutput("b_lock_edge", int'(b_locked), int'(i >= 19));
        end
        for (int i = 0; i < 20; i++) begin
            getWord(w);
            applyStimulus(w ^ 8'h07, 0);
        end
        checkOutput("sat_cnt", int'(b_cnt), 15);
        checkOutput("sat_error", int'(b_error), 1);
        checkOutput("sat_locked", int'(b_locked), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
